// File: rtl/fpu_f32_mul_pipe_if.sv
// Handshake and data bundle for the pipelined binary32 multiplier.
// The slave side is the multiplier and the master side is its user.
interface fpu_f32_mul_pipe_if #(
  parameter int TAG_W = 4
) ();
  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [TAG_W-1:0] IN_TAG;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      O;
  logic [TAG_W-1:0] OUT_TAG;
  logic [3:0]       FLAGS;

  modport slave (
    input  IN_VALID, A, B, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, O, OUT_TAG, FLAGS
  );

  modport master (
    output IN_VALID, A, B, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, O, OUT_TAG, FLAGS
  );
endinterface

// File: rtl/fpu_f32_mul_pipe.sv
// Pipelined IEEE-754 binary32 multiplier: flush-to-zero inputs and outputs, round to nearest even.
// Each stage has a valid bit, and empty stages are filled even while the output is stalled.
module fpu_f32_mul_pipe #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  fpu_f32_mul_pipe_if.slave bus
);

  localparam int L = LATENCY;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // State passed from the multiply half of the datapath to the round half.
  typedef struct packed {
    logic               special;
    logic [31:0]        spec_res;
    logic [3:0]         spec_flags;
    logic               sign;
    logic signed [9:0]  exp_sum;
    logic [47:0]        prod;
  } mid_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
  } res_t;

  function automatic mid_t unpack_mul(input logic [31:0] a, input logic [31:0] b);
    mid_t m;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sgn    = a[31] ^ b[31];

    m         = '0;
    m.sign    = sgn;
    m.exp_sum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    m.prod    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};

    // Zero here includes flushed denormals, so Inf times a denormal is invalid.
    if (a_nan || b_nan) begin
      m.special    = 1'b1;
      m.spec_res   = QNAN;
      m.spec_flags = {(a_nan && !a[22]) || (b_nan && !b[22]), 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      m.special    = 1'b1;
      m.spec_res   = QNAN;
      m.spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      m.special    = 1'b1;
      m.spec_res   = {sgn, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      m.special    = 1'b1;
      m.spec_res   = {sgn, 31'd0};
    end
    return m;
  endfunction

  function automatic res_t round_pack(input mid_t m);
    res_t              r;
    logic [23:0]       mant;
    logic              g, st, up;
    logic [24:0]       mr;
    logic [22:0]       frac;
    logic signed [9:0] e;
    if (m.prod[47]) begin
      mant = m.prod[47:24];
      g    = m.prod[23];
      st   = |m.prod[22:0];
      e    = m.exp_sum + 10'sd1;
    end else begin
      mant = m.prod[46:23];
      g    = m.prod[22];
      st   = |m.prod[21:0];
      e    = m.exp_sum;
    end
    up = g && (st || mant[0]);
    mr = {1'b0, mant} + {24'd0, up};
    // A rounding carry leaves 1.000..0, so the exponent bumps and the fraction clears.
    if (mr[24]) e = e + 10'sd1;
    frac = mr[24] ? mr[23:1] : mr[22:0];

    if (m.special) begin
      r.res   = m.spec_res;
      r.flags = m.spec_flags;
    end else if (e >= 10'sd255) begin
      r.res   = {m.sign, 8'hFF, 23'd0};
      r.flags = 4'b0101;
    end else if (e < 10'sd1) begin
      r.res   = {m.sign, 31'd0};
      r.flags = 4'b0011;
    end else begin
      r.res   = {m.sign, e[7:0], frac};
      r.flags = {3'b000, g | st};
    end
    return r;
  endfunction

  logic [L-1:0]     valid_q;
  logic [L:0]       vin;
  logic [L:0]       adv;
  logic [TAG_W-1:0] tag_q [L];
  logic [31:0]      o_q;
  logic [3:0]       flags_q;
  mid_t             mid_in;
  mid_t             mid_last;
  res_t             res_d;

  // vin[k] is the valid bit offered to stage k; vin[L] is the output valid.
  assign vin = {valid_q, bus.IN_VALID};

  // NOTE: adv gets a full default before the loop, so no path through this block can infer a latch.
  always_comb begin
    adv    = '0;
    adv[L] = bus.OUT_READY;
    for (int k = L - 1; k >= 0; k--) adv[k] = !valid_q[k] || adv[k+1];
  end

  assign mid_in = unpack_mul(bus.A, bus.B);

  generate
    if (L == 1) begin : g_single
      assign mid_last = mid_in;
    end else begin : g_multi
      mid_t mid_q [L-1];

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int k = 0; k < L - 1; k++) mid_q[k] <= '0;
        end else begin
          if (adv[0] && vin[0]) mid_q[0] <= mid_in;
          for (int k = 1; k < L - 1; k++)
            if (adv[k] && vin[k]) mid_q[k] <= mid_q[k-1];
        end
      end

      assign mid_last = mid_q[L-2];
    end
  endgenerate

  assign res_d = round_pack(mid_last);

  // NOTE: the pipeline is only a few words wide, so every register, tag array included, is reset; O, OUT_TAG and FLAGS therefore read 0 out of reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int k = 0; k < L; k++) tag_q[k] <= '0;
      o_q     <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every stage samples its upstream neighbour's old value.
      valid_q <= (valid_q & ~adv[L-1:0]) | (vin[L-1:0] & adv[L-1:0]);
      if (adv[0] && vin[0]) tag_q[0] <= bus.IN_TAG;
      for (int k = 1; k < L; k++)
        if (adv[k] && vin[k]) tag_q[k] <= tag_q[k-1];
      if (adv[L-1] && vin[L-1]) begin
        o_q     <= res_d.res;
        flags_q <= res_d.flags;
      end
    end
  end

  assign bus.IN_READY  = adv[0];
  assign bus.OUT_VALID = vin[L];
  assign bus.O         = o_q;
  assign bus.OUT_TAG   = tag_q[L-1];
  assign bus.FLAGS     = flags_q;

endmodule

// File: tb/tb_fpu_f32_mul_pipe.sv
// Self-checking bench for fpu_f32_mul_pipe: random and directed operands are checked against a
// real-number reference (exact double product, then RNE/FTZ to binary32) kept in a scoreboard.
module tb_fpu_f32_mul_pipe;

  localparam int LATENCY = 3;
  localparam int TAG_W   = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  fpu_f32_mul_pipe_if #(.TAG_W(TAG_W)) bus ();

  fpu_f32_mul_pipe #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  bit free_run  = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_val  = 1'b1;
  bit drv_done   = 1'b0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [35:0]      res;
    int               cyc;
    bit               free;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the product of two binary32 normals is exact in a double; round that to binary32.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, an, bn, ai, bi, az, bz, up;
    real         ra, rb;
    logic [63:0] bits;
    logic [22:0] keep, frac;
    logic [28:0] rem;
    logic [24:0] m;
    int          e;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return {32'h7FC00000, (an && !a[22]) || (bn && !b[22]), 3'b000};
    if ((ai && bz) || (bi && az)) return {32'h7FC00000, 4'b1000};
    if (ai || bi) return {s, 8'hFF, 23'd0, 4'b0000};
    if (az || bz) return {s, 31'd0, 4'b0000};
    ra   = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
    rb   = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    bits = $realtobits(ra * rb);
    e    = int'(bits[62:52]) - 896;
    keep = bits[51:29];
    rem  = bits[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    m    = {2'b01, keep} + 25'(up);
    if (m[24]) e++;
    frac = m[24] ? 23'd0 : m[22:0];
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
    if (e < 1) return {s, 31'd0, 4'b0011};
    return {s, 8'(e), frac, 3'b000, rem != 0};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r1, r2, r3;
    logic        s;
    int          c;
    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    s  = r1[31];
    c  = int'($urandom_range(0, 15));
    case (c)
      0:       return {s, 31'd0};
      1:       return {s, 8'd0, r1[22:0]};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 1'b1, r1[21:0]};
      4:       return {s, 8'hFF, 1'b0, r1[21:1], 1'b1};
      5:       return {s, 8'($urandom_range(1, 20)), r1[22:0]};
      6:       return {s, 8'($urandom_range(235, 254)), r1[22:0]};
      7, 8:    return {s, 8'($urandom_range(100, 154)), r1[22:0] & r2[22:0] & r3[22:0]};
      default: return {s, 8'($urandom_range(1, 254)), r1[22:0]};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    int n = 0;
    bus.IN_VALID = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.IN_TAG   = t;
    @(negedge CLK);
    while (!bus.IN_READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.IN_READY) check("send_timeout", 64'(bus.IN_READY), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  always @(posedge CLK) cycle++;

  initial begin
    bus.OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Single compare process: scoreboard pop/compare, latency, hold-while-stalled, then push.
  logic [63:0] prev_out;
  bit          prev_stall = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!nRST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", 64'({bus.OUT_VALID, bus.O, bus.OUT_TAG, bus.FLAGS}), prev_out);
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'(bus.OUT_VALID), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", 64'({bus.OUT_TAG, bus.O, bus.FLAGS}), 64'({e.tag, e.res}));
          if (e.free) check("latency", 64'(cycle - e.cyc), 64'(LATENCY));
        end
      end
      if (bus.IN_VALID && bus.IN_READY)
        sb.push_back('{bus.IN_TAG, ref_mul(bus.A, bus.B), cycle, free_run});
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      prev_out   = 64'({bus.OUT_VALID, bus.O, bus.OUT_TAG, bus.FLAGS});
    end
  end

  localparam int NV = 9;
  localparam logic [31:0] VA [NV] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000,
                                      32'h7F7FFFFF, 32'h00800000, 32'h7F800001, 32'h3F800001,
                                      32'h3F800003};
  localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000,
                                      32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3FC00000,
                                      32'h3FC00000};
  localparam logic [35:0] VR [NV] = '{{32'h40400000, 4'b0000}, {32'hC0C00000, 4'b0000},
                                      {32'h3F800002, 4'b0001}, {32'h7FC00000, 4'b1000},
                                      {32'h7F800000, 4'b0101}, {32'h00000000, 4'b0011},
                                      {32'h7FC00000, 4'b1000}, {32'h3FC00002, 4'b0001},
                                      {32'h3FC00004, 4'b0001}};

  initial begin
    int t0;
    int n;
    logic [TAG_W-1:0] tag = '0;
    bus.IN_VALID = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.IN_TAG   = '0;

    #1;
    check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_o",         64'(bus.O),         64'd0);
    check("rst_out_tag",   64'(bus.OUT_TAG),   64'd0);
    check("rst_flags",     64'(bus.FLAGS),     64'd0);
    #22 nRST = 1'b1;
    @(negedge CLK);
    check("in_ready_after_rst", 64'(bus.IN_READY), 64'd1);
    @(posedge CLK);
    #1;

    // Pin the reference model on hand-computed vectors.
    for (int i = 0; i < NV; i++) check($sformatf("model_vec%0d", i), 64'(ref_mul(VA[i], VB[i])), 64'(VR[i]));

    // Free-running output: directed vectors, then back-to-back random for throughput/latency.
    ready_val = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    free_run = 1'b1;
    for (int i = 0; i < NV; i++) send(VA[i], VB[i], tag++);
    t0 = cycle;
    for (int i = 0; i < 1000; i++) send(rand_op(), rand_op(), tag++);
    check("throughput_cycles", 64'(cycle - t0), 64'd1000);
    bus.IN_VALID = 1'b0;
    drain();
    free_run = 1'b0;

    // Backpressure: stall output, stream 8 tagged ops, then release with random ready.
    ready_val = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), TAG_W'(i));
        bus.IN_VALID = 1'b0;
        drv_done = 1'b1;
      end
    join_none
    repeat (12) @(posedge CLK);
    #2;
    check("bp_accepted", 64'(sb.size()), 64'(LATENCY));
    check("bp_in_ready", 64'(bus.IN_READY), 64'd0);
    check("bp_out_valid", 64'(bus.OUT_VALID), 64'd1);
    rand_ready = 1'b1;
    n = 0;
    while (!drv_done && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    #2;
    check("bp_driver_done", 64'(drv_done), 64'd1);
    drain();

    // Random traffic with random gaps and random output ready.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
      end
      send(rand_op(), rand_op(), tag++);
    end
    bus.IN_VALID = 1'b0;
    drain();
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Reset with two operations in flight.
    send(32'h3FC00000, 32'h40000000, 4'hA);
    send(32'hC0000000, 32'h40400000, 4'hB);
    bus.IN_VALID = 1'b0;
    #2 nRST = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("midrst_o",         64'(bus.O),         64'd0);
    check("midrst_out_tag",   64'(bus.OUT_TAG),   64'd0);
    check("midrst_flags",     64'(bus.FLAGS),     64'd0);
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b1;
    @(negedge CLK);
    check("midrst_in_ready", 64'(bus.IN_READY), 64'd1);
    repeat (10) @(negedge CLK);
    check("midrst_no_stale", 64'(bus.OUT_VALID), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
